id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register for the five-stage MIPS datapath. It sits directly downstream of the instruction decoder and register file, and captures the decoder control word plus the ID-stage operands each cycle. It contains the load-use hazard detector: on a hazard it stalls PC/IF-ID and injects a bubble into EX. A branch flush squashes the instruction being latched.

---
 rtl/id_ex_pipe_reg.sv | 156 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the five-stage MIPS datapath, with the
// load-use hazard detector folded in.
//
// Each rising edge captures the decoder control word and the ID operands.
// A load in EX whose destination (rt) feeds the instruction now in ID
// raises stall_o for one cycle, which holds PC and IF/ID, and turns this
// edge's capture into a bubble. A taken branch (flush_i) also turns the
// capture into a bubble, and it suppresses the stall so fetch can redirect.
//
// Optional feature: define ID_EX_BUBBLE_CNT_EN to build a saturating
// 32-bit counter of load-use bubbles on bubble_cnt_o. Without the macro,
// bubble_cnt_o is tied to zero and the port list is unchanged.
//
// There is no valid/ready handshake. The block advances on every edge.
// valid_o only marks whether the EX slot holds a real instruction (1) or a
// bubble (0); downstream stages never back-pressure this register.
`timescale 1ns/1ps

module id_ex_pipe_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // decoder control for the instruction in ID
  input  logic              branch_i,
  input  logic              mem_to_reg_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic              reg_dst_i,
  input  logic [2:0]        alu_op_i,
  // ID operands (imm_i arrives already sign-extended)
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [5:0]        funct_i,
  input  logic              flush_i,
  // registered control toward EX
  output logic              branch_o,
  output logic              mem_to_reg_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              alu_src_o,
  output logic              reg_write_o,
  output logic              reg_dst_o,
  output logic [2:0]        alu_op_o,
  // registered data toward EX
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic [5:0]        funct_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [31:0]       bubble_cnt_o
);

  logic loadUseHaz;
  logic loadBubble;

  // Load-use detect: registered EX load destination against live ID sources.
  // A load into $0 never produces a value anyone waits for.
  always_comb begin
    loadUseHaz = mem_read_o && (rt_addr_o != 5'd0) &&
                 ((rt_addr_o == rs_addr_i) || (rt_addr_o == rt_addr_i));
    loadBubble = flush_i || loadUseHaz;
  end

  // A flush wins over the stall: the held instruction is being discarded.
  assign stall_o = loadUseHaz & ~flush_i;

  // Control word and valid: zeroed on a bubble so EX performs no side effect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_o     <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      alu_src_o    <= 1'b0;
      reg_write_o  <= 1'b0;
      reg_dst_o    <= 1'b0;
      alu_op_o     <= 3'b000;
      valid_o      <= 1'b0;
    end else if (loadBubble) begin
      branch_o     <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      alu_src_o    <= 1'b0;
      reg_write_o  <= 1'b0;
      reg_dst_o    <= 1'b0;
      alu_op_o     <= 3'b000;
      valid_o      <= 1'b0;
    end else begin
      branch_o     <= branch_i;
      mem_to_reg_o <= mem_to_reg_i;
      mem_read_o   <= mem_read_i;
      mem_write_o  <= mem_write_i;
      alu_src_o    <= alu_src_i;
      reg_write_o  <= reg_write_i;
      reg_dst_o    <= reg_dst_i;
      alu_op_o     <= alu_op_i;
      valid_o      <= 1'b1;
    end
  end

  // Data and specifier fields always capture; in a bubble they are ignored
  // downstream but stay deterministic because they track the ID inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_plus4_o <= '0;
      rs_data_o  <= '0;
      rt_data_o  <= '0;
      imm_o      <= '0;
      rs_addr_o  <= 5'd0;
      rt_addr_o  <= 5'd0;
      rd_addr_o  <= 5'd0;
      funct_o    <= 6'd0;
    end else begin
      pc_plus4_o <= pc_plus4_i;
      rs_data_o  <= rs_data_i;
      rt_data_o  <= rt_data_i;
      imm_o      <= imm_i;
      rs_addr_o  <= rs_addr_i;
      rt_addr_o  <= rt_addr_i;
      rd_addr_o  <= rd_addr_i;
      funct_o    <= funct_i;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubbleCnt;

  // Count load-use bubbles only (flush bubbles excluded), saturating at max.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubbleCnt <= 32'h0;
    end else if (stall_o && (bubbleCnt != 32'hFFFF_FFFF)) begin
      bubbleCnt <= bubbleCnt + 32'd1;
    end
  end

  assign bubble_cnt_o = bubbleCnt;
`else
  assign bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg. A small reference model computes
// the expected register contents at every edge and pushes them onto exp_q;
// the scoreboard pops and compares on the falling edge. Scenario tasks add
// targeted inline checks of stall_o and selected outputs.
// Define ID_EX_BUBBLE_CNT_EN for both files to exercise the counter.
`timescale 1ns/1ps

module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              branch;
    logic              memToReg;
    logic              memRead;
    logic              memWrite;
    logic              aluSrc;
    logic              regWrite;
    logic              regDst;
    logic [2:0]        aluOp;
    logic              valid;
    logic [DATA_W-1:0] pcPlus4;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rsAddr;
    logic [4:0]        rtAddr;
    logic [4:0]        rdAddr;
    logic [5:0]        funct;
    logic [31:0]       bubbleCnt;
  } out_t;

  localparam int W = $bits(out_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ID-side stimulus
  logic              branchIn, memToRegIn, memReadIn, memWriteIn;
  logic              aluSrcIn, regWriteIn, regDstIn, flushIn;
  logic [2:0]        aluOpIn;
  logic [DATA_W-1:0] pcPlus4In, rsDataIn, rtDataIn, immIn;
  logic [4:0]        rsAddrIn, rtAddrIn, rdAddrIn;
  logic [5:0]        functIn;

  // DUT outputs
  logic              branchOut, memToRegOut, memReadOut, memWriteOut;
  logic              aluSrcOut, regWriteOut, regDstOut, validOut, stallOut;
  logic [2:0]        aluOpOut;
  logic [DATA_W-1:0] pcPlus4Out, rsDataOut, rtDataOut, immOut;
  logic [4:0]        rsAddrOut, rtAddrOut, rdAddrOut;
  logic [5:0]        functOut;
  logic [31:0]       bubbleCntOut;

  id_ex_pipe_reg #(.DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .branch_i(branchIn), .mem_to_reg_i(memToRegIn), .mem_read_i(memReadIn),
    .mem_write_i(memWriteIn), .alu_src_i(aluSrcIn), .reg_write_i(regWriteIn),
    .reg_dst_i(regDstIn), .alu_op_i(aluOpIn),
    .pc_plus4_i(pcPlus4In), .rs_data_i(rsDataIn), .rt_data_i(rtDataIn),
    .imm_i(immIn), .rs_addr_i(rsAddrIn), .rt_addr_i(rtAddrIn),
    .rd_addr_i(rdAddrIn), .funct_i(functIn), .flush_i(flushIn),
    .branch_o(branchOut), .mem_to_reg_o(memToRegOut), .mem_read_o(memReadOut),
    .mem_write_o(memWriteOut), .alu_src_o(aluSrcOut), .reg_write_o(regWriteOut),
    .reg_dst_o(regDstOut), .alu_op_o(aluOpOut),
    .pc_plus4_o(pcPlus4Out), .rs_data_o(rsDataOut), .rt_data_o(rtDataOut),
    .imm_o(immOut), .rs_addr_o(rsAddrOut), .rt_addr_o(rtAddrOut),
    .rd_addr_o(rdAddrOut), .funct_o(functOut), .valid_o(validOut),
    .stall_o(stallOut), .bubble_cnt_o(bubbleCntOut)
  );

  out_t gotOut;
  assign gotOut = {branchOut, memToRegOut, memReadOut, memWriteOut, aluSrcOut,
                   regWriteOut, regDstOut, aluOpOut, validOut, pcPlus4Out,
                   rsDataOut, rtDataOut, immOut, rsAddrOut, rtAddrOut,
                   rdAddrOut, functOut, bubbleCntOut};

  int nVectors = 0;
  int nErrors  = 0;

  // reference model
  out_t        m = '0;
  out_t        mNext;
  logic        mHaz;
  logic        cntLoadReq = 1'b0;
  logic [31:0] cntLoadVal = 32'h0;
  logic [31:0] cntBase;
  logic [W-1:0] exp_q[$];

  always_comb begin
    mHaz = m.memRead && (m.rtAddr != 5'd0) &&
           ((m.rtAddr == rsAddrIn) || (m.rtAddr == rtAddrIn));
    cntBase = cntLoadReq ? cntLoadVal : m.bubbleCnt;
    mNext = '0;
    if (!rst) begin
      mNext.pcPlus4 = pcPlus4In;
      mNext.rsData  = rsDataIn;
      mNext.rtData  = rtDataIn;
      mNext.imm     = immIn;
      mNext.rsAddr  = rsAddrIn;
      mNext.rtAddr  = rtAddrIn;
      mNext.rdAddr  = rdAddrIn;
      mNext.funct   = functIn;
      if (!(flushIn || mHaz)) begin
        mNext.branch   = branchIn;
        mNext.memToReg = memToRegIn;
        mNext.memRead  = memReadIn;
        mNext.memWrite = memWriteIn;
        mNext.aluSrc   = aluSrcIn;
        mNext.regWrite = regWriteIn;
        mNext.regDst   = regDstIn;
        mNext.aluOp    = aluOpIn;
        mNext.valid    = 1'b1;
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      mNext.bubbleCnt = cntBase;
      if (mHaz && !flushIn && (cntBase != 32'hFFFF_FFFF))
        mNext.bubbleCnt = cntBase + 32'd1;
`endif
    end
  end

  // model register: expected outputs queued at every edge
  always @(posedge clk) begin
    m <= mNext;
    exp_q.push_back(mNext);
  end

  // scoreboard: compare registered outputs away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] expv;
      expv = exp_q.pop_front();
      nVectors++;
      if (gotOut !== out_t'(expv)) begin
        nErrors++;
        $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, gotOut, expv);
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_idle();
    {branchIn, memToRegIn, memReadIn, memWriteIn} = '0;
    {aluSrcIn, regWriteIn, regDstIn, flushIn} = '0;
    aluOpIn = 3'b000;
    pcPlus4In = '0; rsDataIn = '0; rtDataIn = '0; immIn = '0;
    rsAddrIn = 5'd0; rtAddrIn = 5'd0; rdAddrIn = 5'd0; functIn = 6'd0;
  endtask

  task automatic set_instr(input logic memRead, input logic regWrite,
                           input logic regDst, input logic [2:0] aluOp,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd);
    branchIn   = 1'b0;
    memReadIn  = memRead;
    memToRegIn = memRead;
    aluSrcIn   = memRead;
    memWriteIn = 1'b0;
    regWriteIn = regWrite;
    regDstIn   = regDst;
    aluOpIn    = aluOp;
    rsAddrIn   = rs;
    rtAddrIn   = rt;
    rdAddrIn   = rd;
    functIn    = memRead ? 6'd0 : 6'h20;
    pcPlus4In  = $urandom;
    rsDataIn   = $urandom;
    rtDataIn   = $urandom;
    immIn      = $urandom;
    flushIn    = 1'b0;
  endtask

  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_instr(1'b1, 1'b1, 1'b0, 3'b000, rs, rt, 5'd0);
  endtask

  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
    set_instr(1'b0, 1'b1, 1'b1, 3'b010, rs, rt, rd);
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_lw(5'd1, 5'd2);
    @(posedge clk); #1;
    nVectors++;
    if (gotOut !== out_t'(0) || stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL reset_state got=%h stall=%b exp all 0", gotOut, stallOut);
    end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    set_add(5'd8, 5'd9, 5'd10);
    #1;
    nVectors++;
    if (stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL pass_stall got=%b exp=0", stallOut);
    end
    @(posedge clk); #1;
    nVectors++;
    if (validOut !== 1'b1 || aluOpOut !== 3'b010 || rdAddrOut !== 5'd10 ||
        regDstOut !== 1'b1 || regWriteOut !== 1'b1 || stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL pass_through valid=%b aluop=%b rd=%0d stall=%b exp 1/010/10/0",
               validOut, aluOpOut, rdAddrOut, stallOut);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] expCnt;
    @(negedge clk);
    set_lw(5'd8, 5'd9);
    @(negedge clk);
`ifdef ID_EX_BUBBLE_CNT_EN
    expCnt = m.bubbleCnt + 32'd1;
`else
    expCnt = 32'h0;
`endif
    set_add(5'd9, 5'd3, 5'd11);
    #1;
    nVectors++;
    if (stallOut !== 1'b1) begin
      nErrors++;
      $display("FAIL load_use_stall got=%b exp=1", stallOut);
    end
    @(posedge clk); #1;
    nVectors++;
    if (memReadOut !== 1'b0 || regWriteOut !== 1'b0 || validOut !== 1'b0 ||
        stallOut !== 1'b0 || bubbleCntOut !== expCnt) begin
      nErrors++;
      $display("FAIL load_use_bubble rd=%b rw=%b v=%b stall=%b cnt=%0d exp 0/0/0/0/%0d",
               memReadOut, regWriteOut, validOut, stallOut, bubbleCntOut, expCnt);
    end
    @(posedge clk); #1;
    nVectors++;
    if (validOut !== 1'b1 || rsAddrOut !== 5'd9 || regWriteOut !== 1'b1) begin
      nErrors++;
      $display("FAIL load_use_replay v=%b rs=%0d rw=%b exp 1/9/1",
               validOut, rsAddrOut, regWriteOut);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    set_lw(5'd4, 5'd0);
    @(negedge clk);
    set_add(5'd0, 5'd0, 5'd12);
    #1;
    nVectors++;
    if (stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL zero_reg_stall got=%b exp=0", stallOut);
    end
    @(posedge clk); #1;
    nVectors++;
    if (validOut !== 1'b1 || rdAddrOut !== 5'd12) begin
      nErrors++;
      $display("FAIL zero_reg_capture v=%b rd=%0d exp 1/12", validOut, rdAddrOut);
    end
  endtask

  task automatic test_flush();
    logic [31:0] expCnt;
    @(negedge clk);
    set_lw(5'd2, 5'd9);
    @(negedge clk);
    expCnt = m.bubbleCnt;
    set_add(5'd9, 5'd9, 5'd13);
    flushIn = 1'b1;
    #1;
    nVectors++;
    if (stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL flush_stall got=%b exp=0", stallOut);
    end
    @(posedge clk); #1;
    nVectors++;
    if (validOut !== 1'b0 || memReadOut !== 1'b0 || bubbleCntOut !== expCnt) begin
      nErrors++;
      $display("FAIL flush_bubble v=%b rd=%b cnt=%0d exp 0/0/%0d",
               validOut, memReadOut, bubbleCntOut, expCnt);
    end
    @(negedge clk);
    flushIn = 1'b0;
    #1;
    nVectors++;
    if (stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL flush_after_stall got=%b exp=0", stallOut);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    set_lw(5'd3, 5'd7);
    @(negedge clk);
    set_add(5'd1, 5'd7, 5'd14);
    #1;
    nVectors++;
    if (stallOut !== 1'b1) begin
      nErrors++;
      $display("FAIL rst_mid_pre_stall got=%b exp=1", stallOut);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    nVectors++;
    if (gotOut !== out_t'(0) || stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL rst_mid_clear got=%h stall=%b exp all 0", gotOut, stallOut);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nVectors++;
    if (stallOut !== 1'b0) begin
      nErrors++;
      $display("FAIL rst_mid_post_stall got=%b exp=0", stallOut);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    @(negedge clk);
    set_lw(5'd1, 5'd5);
    @(negedge clk);
    set_lw(5'd5, 5'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (stallOut === 1'b1) stalls++;
      @(negedge clk);
    end
    set_add(5'd5, 5'd6, 5'd15);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (stallOut === 1'b1) stalls++;
      @(negedge clk);
    end
    nVectors++;
    if (stalls != 2) begin
      nErrors++;
      $display("FAIL back_to_back_stalls got=%0d exp=2", stalls);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      set_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)));
      branchIn   = 1'($urandom_range(0, 1));
      memWriteIn = 1'($urandom_range(0, 1));
      flushIn    = ($urandom_range(0, 7) == 0);
      #1;
      nVectors++;
      if (stallOut !== (mHaz & ~flushIn)) begin
        nErrors++;
        $display("FAIL random_stall c=%0d got=%b exp=%b", c, stallOut, mHaz & ~flushIn);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic test_saturation();
    @(negedge clk);
    set_idle();
    #2;
    force dut.bubbleCnt = 32'hFFFF_FFFE;
    release dut.bubbleCnt;
    cntLoadVal = 32'hFFFF_FFFE;
    cntLoadReq = 1'b1;
    @(negedge clk);
    cntLoadReq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_lw(5'd2, 5'd3);
      @(negedge clk);
      set_add(5'd3, 5'd4, 5'd16);
      @(posedge clk); #1;
      nVectors++;
      if (bubbleCntOut !== 32'hFFFF_FFFF) begin
        nErrors++;
        $display("FAIL saturation k=%0d got=%h exp=ffffffff", k, bubbleCntOut);
      end
      @(negedge clk);
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    set_idle();
    test_reset();
    test_pass_through();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_saturation();
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
    $finish;
  end

endmodule
